axi_tile_rd_arbiter: RTL

- Multi-channel AXI read master for the video-splicing path.
- Fetches one tile line at a time from per-channel ping-pong frame buffers in DDR, and arbitrates between CH_NUM channels with round-robin.
- Streams read beats, tagged by channel and end-of-line, to the per-channel line buffers feeding the HDMI timing block.
- Successor to the single-stream quadrant reader: generalised channel count, tile geometry, burst length and line/frame tracking.

---
 rtl/axi_tile_rd_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_tile_rd_arbiter.sv
// axi_tile_rd_arbiter
//   Multi-channel AXI read master. Each channel fetches one tile line from
//   its ping/pong frame buffer in DDR. Channels take turns in round-robin
//   order, and a line is fetched as several bursts of BURST_LEN beats.
//   Read beats go out tagged with their channel and an end-of-line flag.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   frame_start         vsync; its falling edge starts a new output frame
//   line_req[CH_NUM]    per-channel: the line buffer can take one full line
//   frame_sel[CH_NUM]   per-channel ping/pong select, latched at frame start
//   axi_ar*             AR channel (one burst outstanding at a time)
//   axi_r*              R channel; axi_rready follows out_ready
//   out_*               beat stream to the line buffers (valid/data pass through)
//   frame_done[CH_NUM]  channel has fetched all TILE_HEIGHT lines this frame
//   err_rid             sticky flag: an rid did not match the granted channel
//
// Build option
//   AXI_TILE_RD_RID_CHECK_EN  builds the rid compare. Without it, err_rid is tied to 0.

// Per-channel line tracking: line counter, frame-done flag, buffer select.
module axi_tile_rd_ch #(
  parameter int LCW         = 8,
  parameter int TILE_HEIGHT = 180
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           sel_in,
  input  logic           inc,
  output logic [LCW-1:0] line_cnt,
  output logic           frame_done,
  output logic           buf_sel
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_cnt   <= '0;
      frame_done <= 1'b0;
      buf_sel    <= 1'b0;
    end else if (clr) begin
      line_cnt   <= '0;
      frame_done <= 1'b0;
      buf_sel    <= sel_in;
    end else if (inc && !frame_done) begin
      // The counter stops at TILE_HEIGHT. A done channel is never granted again.
      if (line_cnt == LCW'(TILE_HEIGHT - 1)) frame_done <= 1'b1;
      line_cnt <= line_cnt + 1'b1;
    end
  end
endmodule

module axi_tile_rd_arbiter #(
  parameter int CH_NUM            = 4,
  parameter int CTRL_ADDR_WIDTH   = 28,
  parameter int DQ_WIDTH          = 32,
  parameter int TILE_WIDTH        = 320,
  parameter int TILE_HEIGHT       = 180,
  parameter int BURST_LEN         = 10,
  parameter int FRAME_ADDR_OFFSET = 40960,
  parameter int CH_ADDR_STRIDE    = 81920,
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [CH_NUM-1:0]       line_req,
  input  logic [CH_NUM-1:0]       frame_sel,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  output logic [3:0]              axi_arid,
  output logic [3:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic [1:0]              axi_arburst,
  output logic                    axi_rready,
  input  logic [DQ_WIDTH*8-1:0]   axi_rdata,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  input  logic [3:0]              axi_rid,
  output logic                    out_valid,
  output logic [DQ_WIDTH*8-1:0]   out_data,
  output logic [CW-1:0]           out_ch,
  output logic                    out_eol,
  input  logic                    out_ready,
  output logic [CH_NUM-1:0]       frame_done,
  output logic                    err_rid
);
  localparam int LINE_WORDS = TILE_WIDTH * 16 / (DQ_WIDTH * 8);
  localparam int BW  = $clog2(LINE_WORDS + 1);
  localparam int LCW = $clog2(TILE_HEIGHT + 1);
  localparam int AW  = CTRL_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, DONE} state_t;

  state_t                       state, nstate;
  logic                         fs_q, pend, apply, fall;
  logic [CW-1:0]                ptr, grant, rr_idx;
  logic                         rr_hit;
  logic [AW-1:0]                addr, base_addr;
  logic [BW-1:0]                beat_cnt;
  logic [CH_NUM-1:0][LCW-1:0]   line_cnt;
  logic [CH_NUM-1:0]            buf_sel, elig;
  logic                         acc, last_burst;

  assign fall  = fs_q & ~frame_start;
  // A frame start only takes effect in IDLE, so it never cuts a line short.
  assign apply = (state == IDLE) && pend;
  assign elig  = line_req & ~frame_done;
  assign acc   = (state == DATA) && axi_rvalid && out_ready;
  assign last_burst = (beat_cnt == BW'(LINE_WORDS - 1));

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    axi_tile_rd_ch #(.LCW(LCW), .TILE_HEIGHT(TILE_HEIGHT)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .clr        (apply),
      .sel_in     (frame_sel[g]),
      .inc        ((state == DONE) && (grant == CW'(g))),
      .line_cnt   (line_cnt[g]),
      .frame_done (frame_done[g]),
      .buf_sel    (buf_sel[g])
    );
  end

  // Round-robin: the first eligible channel at or after ptr wins.
  always_comb begin
    int c;
    c      = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      c = (int'(ptr) + i) % CH_NUM;
      if (!rr_hit && elig[c]) begin
        rr_hit = 1'b1;
        rr_idx = CW'(c);
      end
    end
  end

  assign base_addr = AW'(CH_ADDR_STRIDE) * AW'(rr_idx)
                   + (buf_sel[rr_idx] ? AW'(FRAME_ADDR_OFFSET) : '0)
                   + AW'(line_cnt[rr_idx]) * AW'(LINE_WORDS * 8);

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (!pend && |elig) nstate = ARB;
      ARB:  nstate = rr_hit ? ADDR : IDLE;
      ADDR: if (axi_arready) nstate = DATA;
      DATA: if (acc && axi_rlast) nstate = last_burst ? DONE : ADDR;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fs_q     <= 1'b0;
      pend     <= 1'b0;
      ptr      <= '0;
      grant    <= '0;
      addr     <= '0;
      beat_cnt <= '0;
    end else begin
      state <= nstate;
      fs_q  <= frame_start;
      if (fall)       pend <= 1'b1;
      else if (apply) pend <= 1'b0;
      if (state == ARB && rr_hit) begin
        grant    <= rr_idx;
        ptr      <= (rr_idx == CW'(CH_NUM - 1)) ? '0 : rr_idx + 1'b1;
        beat_cnt <= '0;
        addr     <= base_addr;
      end
      if (acc) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (axi_rlast) addr <= addr + AW'(BURST_LEN * 8);
      end
    end
  end

  assign axi_arvalid = (state == ADDR);
  assign axi_araddr  = addr;
  assign axi_arid    = 4'(grant);
  assign axi_arlen   = 4'(BURST_LEN - 1);
  assign axi_arsize  = 3'b101;
  assign axi_arburst = 2'b01;
  assign axi_rready  = out_ready;
  assign out_valid   = axi_rvalid;
  assign out_data    = axi_rdata;
  assign out_ch      = grant;
  // The counter holds LINE_WORDS-1 while the closing beat of the last burst is on the bus.
  assign out_eol     = (state == DATA) && axi_rvalid && axi_rlast && last_burst;

`ifdef AXI_TILE_RD_RID_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               err_q <= 1'b0;
    else if (acc && axi_rid != 4'(grant))   err_q <= 1'b1;
  end
  assign err_rid = err_q;
`else
  logic unused_rid;
  assign unused_rid = ^axi_rid;
  assign err_rid    = 1'b0;
`endif
endmodule
